// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and default frame
// configuration shared by the receiver, transmitter and baud generator.
package uart_pkg;

    localparam int UART_DATA_BITS  = 8;
    localparam int UART_OVERSAMPLE = 16;
    localparam int UART_SB_TICKS   = 16;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_e;

    function automatic int uart_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/bit_sync.sv
// Two-flop synchroniser for a single asynchronous input bit.
// Ports: i_clock, i_reset (sync, active high), i_d (async in), o_q (synced).
module bit_sync #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic i_clock,
    input  logic i_reset,
    input  logic i_d,
    output logic o_q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= i_d;
            sync_q <= meta_q;
        end
    end

    assign o_q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 16x oversampled start/data/[parity]/stop deserialiser.
// Ports: i_clock, i_reset (sync, active high), i_baud_tick (oversample
//   tick), i_rx (async line, idles high), o_data (last good word),
//   o_rx_done / o_frame_err (1-cycle pulses), o_busy (not idle),
//   o_parity_err (1-cycle pulse, only with UART_RX_PARITY_EN defined).
// Optional feature macro: UART_RX_PARITY_EN adds a parity bit and state.
module uart_rx
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = UART_DATA_BITS,
    parameter int OVERSAMPLE = UART_OVERSAMPLE,
    parameter int SB_TICKS   = UART_SB_TICKS,
    parameter int PARITY_ODD = 0
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    input  logic                 i_baud_tick,
    input  logic                 i_rx,
    output logic [DATA_BITS-1:0] o_data,
    output logic                 o_rx_done,
    output logic                 o_frame_err,
`ifdef UART_RX_PARITY_EN
    output logic                 o_parity_err,
`endif
    output logic                 o_busy
);

    localparam int CNT_W = $clog2(uart_max(OVERSAMPLE, SB_TICKS));
    localparam int IDX_W = $clog2(DATA_BITS + 1);

    localparam logic [2:0] S_IDLE   = IDLE;
    localparam logic [2:0] S_START  = START;
    localparam logic [2:0] S_DATA   = DATA;
    localparam logic [2:0] S_PARITY = PARITY;
    localparam logic [2:0] S_STOP   = STOP;

    localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_BIT  = CNT_W'(OVERSAMPLE - 1);
    localparam logic [CNT_W-1:0] CNT_STOP = CNT_W'(SB_TICKS - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

`ifdef UART_RX_PARITY_EN
    localparam logic [2:0] S_AFTER_DATA = S_PARITY;
`else
    localparam logic [2:0] S_AFTER_DATA = S_STOP;
`endif

    logic                 rx_s;

    logic [2:0]           state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 done_q, done_d;
    logic                 ferr_q, ferr_d;
    logic                 pmis_q, pmis_d;
    logic                 perr_q, perr_d;

    // Parity sense only matters when the parity stage is built in.
    logic                 unused_cfg;
    assign unused_cfg = PARITY_ODD[0] & 1'b0;

    bit_sync #(
        .RESET_VAL (1'b1)
    ) u_rx_sync (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .i_d     (i_rx),
        .o_q     (rx_s)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        data_d  = data_q;
        pmis_d  = pmis_q;
        // Status strobes are single-cycle regardless of tick activity.
        done_d  = 1'b0;
        ferr_d  = 1'b0;
        perr_d  = 1'b0;

        if (i_baud_tick) begin
            case (state_q)
                S_IDLE: begin
                    cnt_d = '0;
                    idx_d = '0;
                    if (!rx_s) begin
                        state_d = S_START;
                        pmis_d  = 1'b0;
                    end
                end

                S_START: begin
                    if (cnt_q == CNT_MID) begin
                        cnt_d = '0;
                        idx_d = '0;
                        // A line that is high again at mid-bit was noise.
                        state_d = rx_s ? S_IDLE : S_DATA;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end

                S_DATA: begin
                    if (cnt_q == CNT_BIT) begin
                        cnt_d = '0;
                        // LSB arrives first; right shift leaves it at bit 0.
                        shift_d = shift_q >> 1;
                        shift_d[DATA_BITS-1] = rx_s;
                        idx_d = idx_q + 1'b1;
                        if (idx_q == IDX_LAST) begin
                            idx_d   = '0;
                            state_d = S_AFTER_DATA;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end

`ifdef UART_RX_PARITY_EN
                S_PARITY: begin
                    if (cnt_q == CNT_BIT) begin
                        cnt_d   = '0;
                        // Mismatch when the received bit differs from the
                        // parity expected over the data bits.
                        pmis_d  = rx_s ^ (^shift_q) ^ PARITY_ODD[0];
                        state_d = S_STOP;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
`endif

                S_STOP: begin
                    if (cnt_q == CNT_STOP) begin
                        cnt_d   = '0;
                        state_d = S_IDLE;
                        if (rx_s) begin
                            data_d = shift_q;
                            done_d = 1'b1;
                            perr_d = pmis_q;
                        end else begin
                            ferr_d = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end

                default: begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    idx_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            done_q  <= 1'b0;
            ferr_q  <= 1'b0;
            pmis_q  <= 1'b0;
            perr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            done_q  <= done_d;
            ferr_q  <= ferr_d;
            pmis_q  <= pmis_d;
            perr_q  <= perr_d;
        end
    end

    assign o_data      = data_q;
    assign o_rx_done   = done_q;
    assign o_frame_err = ferr_q;
    assign o_busy      = (state_q != S_IDLE);

`ifdef UART_RX_PARITY_EN
    assign o_parity_err = perr_q;
`else
    logic unused_perr;
    assign unused_perr = perr_q | pmis_q;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: frames are queued as expectations
// when driven and matched against the receiver's strobes.
module tb_uart_rx;

    logic       clk;
    logic       rst;
    logic       tick;
    logic       rx;
    logic [7:0] data;
    logic       done;
    logic       ferr;
    logic       busy;
`ifdef UART_RX_PARITY_EN
    logic       perr;
`endif

    typedef struct packed {
        logic       ferr;
        logic       perr;
        logic [7:0] data;
    } exp_t;

    exp_t       sb_q[$];
    int         n_checks;
    int         n_fail;
    int         n_done;
    int         n_ferr;
    int         tcnt;
    logic [7:0] last_good;
    logic       prev_done;
    logic       prev_ferr;

    uart_rx #(
        .DATA_BITS  (8),
        .OVERSAMPLE (16),
        .SB_TICKS   (16),
        .PARITY_ODD (0)
    ) dut (
        .i_clock      (clk),
        .i_reset      (rst),
        .i_baud_tick  (tick),
        .i_rx         (rx),
        .o_data       (data),
        .o_rx_done    (done),
        .o_frame_err  (ferr),
`ifdef UART_RX_PARITY_EN
        .o_parity_err (perr),
`endif
        .o_busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One oversample tick every 4 clocks, changed on the falling edge.
    initial begin
        tick = 1'b0;
        tcnt = 0;
        forever begin
            @(negedge clk);
            tcnt++;
            tick = (tcnt % 4 == 0);
        end
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_ticks(input int n);
        repeat (n) begin
            do @(posedge clk); while (tick !== 1'b1);
        end
        #1;
    endtask

    task automatic drive_bit(input logic b, input int n);
        rx = b;
        wait_ticks(n);
    endtask

    // par is the parity bit put on the line; the receiver only sees it
    // when the parity stage is built in.
    task automatic send_frame(input logic [7:0] d, input logic stop_ok,
                              input logic par);
        exp_t e;
        e.ferr = !stop_ok;
        e.perr = stop_ok & (par != ^d);
        e.data = d;
        sb_q.push_back(e);
        drive_bit(1'b0, 16);
        for (int i = 0; i < 8; i++) drive_bit(d[i], 16);
`ifdef UART_RX_PARITY_EN
        drive_bit(par, 16);
`endif
        if (stop_ok) begin
            drive_bit(1'b1, 16);
        end else begin
            drive_bit(1'b0, 12);
            drive_bit(1'b1, 20);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            prev_done = 1'b0;
            prev_ferr = 1'b0;
        end else begin
            if (prev_done) check("done_width", {31'd0, done}, 32'd0);
            if (prev_ferr) check("ferr_width", {31'd0, ferr}, 32'd0);
            if (done || ferr) begin
                if (done) n_done++;
                if (ferr) n_ferr++;
                check("done_ferr_excl", {31'd0, done & ferr}, 32'd0);
                check("busy_after_stop", {31'd0, busy}, 32'd0);
                if (sb_q.size() == 0) begin
                    check("unexpected_event", {30'd0, done, ferr}, 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    check("event_kind", {30'd0, done, ferr},
                          e.ferr ? 32'd1 : 32'd2);
                    if (done) begin
                        check("rx_data", {24'd0, data}, {24'd0, e.data});
                        last_good = e.data;
                    end else begin
                        check("data_kept", {24'd0, data}, {24'd0, last_good});
                    end
`ifdef UART_RX_PARITY_EN
                    check("parity_err", {31'd0, perr}, {31'd0, e.perr});
`endif
                end
            end
            prev_done = done;
            prev_ferr = ferr;
        end
    end

    initial begin
        int exp_done;
        n_checks  = 0;
        n_fail    = 0;
        n_done    = 0;
        n_ferr    = 0;
        last_good = 8'h00;
        exp_done  = 0;
        rst = 1'b1;
        rx  = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_data", {24'd0, data}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_ferr", {31'd0, ferr}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;
        wait_ticks(4);

        send_frame(8'h55, 1'b1, 1'b0);
        exp_done++;
        drive_bit(1'b1, 16);
        check("hold_55", {24'd0, data}, 32'h55);

        // Short low glitch: detected, then rejected at mid-bit.
        drive_bit(1'b0, 5);
        check("glitch_busy", {31'd0, busy}, 32'd1);
        drive_bit(1'b1, 32);
        check("glitch_idle", {31'd0, busy}, 32'd0);
        check("glitch_data", {24'd0, data}, 32'h55);

        send_frame(8'hA3, 1'b0, 1'b0);
        drive_bit(1'b1, 16);
        check("ferr_data", {24'd0, data}, 32'h55);

        send_frame(8'h00, 1'b1, 1'b0);
        send_frame(8'hFF, 1'b1, 1'b0);
        exp_done += 2;
        drive_bit(1'b1, 16);

        // Partial frame 0x96 cut by reset in the middle of bit 3.
        drive_bit(1'b0, 16);
        drive_bit(1'b0, 16);
        drive_bit(1'b1, 16);
        drive_bit(1'b1, 16);
        rx = 1'b0;
        wait_ticks(8);
        check("mid_busy", {31'd0, busy}, 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        last_good = 8'h00;
        check("mrst_data", {24'd0, data}, 32'd0);
        check("mrst_done", {31'd0, done}, 32'd0);
        check("mrst_ferr", {31'd0, ferr}, 32'd0);
        check("mrst_busy", {31'd0, busy}, 32'd0);
        rx = 1'b1;
        wait_ticks(40);

        send_frame(8'h3C, 1'b1, 1'b0);
        exp_done++;
        drive_bit(1'b1, 16);

`ifdef UART_RX_PARITY_EN
        send_frame(8'h07, 1'b1, 1'b0);
        send_frame(8'h07, 1'b1, 1'b1);
        exp_done += 2;
        drive_bit(1'b1, 16);
`endif

        for (int i = 0; i < 2000 && sb_q.size() != 0; i++) @(negedge clk);
        check("sb_drained", sb_q.size(), 32'd0);
        check("done_count", n_done, exp_done);
        check("ferr_count", n_ferr, 32'd1);
        check("final_busy", {31'd0, busy}, 32'd0);
        check("final_data", {24'd0, data}, {24'd0, last_good});

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
